data_mem_responder: RTL

- Responder end of the pipeline CPU's stage-4 data-memory interface.
- Accepts one load/store request per access, stalls the CPU through BUSY_WAIT for a fixed number of cycles, then performs the access.
- Stores: byte, half or word writes with per-lane masking.
- Loads: sign- or zero-extended data returned on READ_DATA.
- Sits between the CPU data port and on-chip SRAM, standing in for the data cache until the cache is built.

---
 rtl/data_mem_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipeline CPU's stage-4 port: stalls for LATENCY
// cycles, then performs a byte/half/word store or a sign/zero-extended load.
module data_mem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  READ_EN,
   input  logic [2:0]  WRITE_EN,
   input  logic [31:0] ADDR,
   input  logic [31:0] WRITE_DATA,
   output logic [31:0] READ_DATA,
   output logic        BUSY_WAIT,
   output logic        MISALIGNED
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                state, state_next;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            ren_q;
   logic [2:0]            wen_q;
   logic [31:0]           mem [DEPTH];

   logic                  req, fire, is_store, is_load;
   logic [1:0]            lane;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           rd_word, ld_val, st_data;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [3:0]            st_be;
   logic                  st_mis, ld_mis, mis_req;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^ADDR[31:ADDR_WIDTH+2];

   assign req      = READ_EN[3] | WRITE_EN[2];
   assign fire     = (state == ACCESS) && (cnt == 4'd0);
   assign is_store = wen_q[2];
   assign is_load  = ren_q[3] & ~wen_q[2];
   assign lane     = addr_q[1:0];
   assign idx      = addr_q[ADDR_WIDTH+1:2];
   assign rd_word  = mem[idx];
   assign byte_sel = rd_word[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
   assign mis_req  = is_store ? st_mis : ld_mis;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      BUSY_WAIT  = 1'b0;
      case (state)
         IDLE: if (req) begin
            BUSY_WAIT  = RESET;
            state_next = ACCESS;
         end
         ACCESS: begin
            BUSY_WAIT = 1'b1;
            if (cnt == 4'd0) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Misaligned accesses align down to the natural boundary of their size.
   always_comb begin
      st_be   = 4'b0000;
      st_data = wdata_q;
      st_mis  = 1'b0;
      case (wen_q[1:0])
         2'b00: begin
            st_be   = 4'b0001 << lane;
            st_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            st_be   = lane[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata_q[15:0]}};
            st_mis  = lane[0];
         end
         2'b10: begin
            st_be   = 4'b1111;
            st_mis  = |lane;
         end
         default: st_be = 4'b0000;
      endcase
   end

   always_comb begin
      ld_val = 32'd0;
      ld_mis = 1'b0;
      case (ren_q[2:0])
         3'b000: ld_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001: begin
            ld_val = {{16{half_sel[15]}}, half_sel};
            ld_mis = lane[0];
         end
         3'b010: begin
            ld_val = rd_word;
            ld_mis = |lane;
         end
         3'b100: ld_val = {24'd0, byte_sel};
         3'b101: begin
            ld_val = {16'd0, half_sel};
            ld_mis = lane[0];
         end
         default: ld_val = 32'd0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt        <= 4'd0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         ren_q      <= 4'd0;
         wen_q      <= 3'd0;
         READ_DATA  <= 32'd0;
         MISALIGNED <= 1'b0;
      end else begin
         MISALIGNED <= fire & mis_req;
         case (state)
            IDLE: if (req) begin
               addr_q  <= ADDR[ADDR_WIDTH+1:0];
               wdata_q <= WRITE_DATA;
               ren_q   <= READ_EN;
               wen_q   <= WRITE_EN;
               cnt     <= 4'(LATENCY - 1);
            end
            ACCESS: begin
               if (cnt != 4'd0)                 cnt       <= cnt - 4'd1;
               else if (is_store && ren_q[3])   READ_DATA <= 32'd0;
               else if (is_load)                READ_DATA <= ld_val;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the array has no reset; contents survive RESET and a write only
   // happens on the final ACCESS cycle, so an aborted access never writes.
   always_ff @(posedge CLK) begin
      if (fire && is_store) begin
         for (int i = 0; i < 4; i++)
            if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
   end

endmodule
